// File: rtl/alarm_controller.sv
// alarm_controller: turns the alarm/time comparator match into a buzzer enable.
// The buzzer stops when the ring time runs out, on snooze or on stop.
// Ports:
//   CLK        system clock, rising edge
//   RST        synchronous active-high reset
//   TICK_1HZ   one-cycle pulse once per second
//   SAME       level, high while current time equals alarm time
//   ALARM_EN   level, alarm armed
//   SNOOZE     one-cycle snooze button pulse
//   STOP       one-cycle stop button pulse
//   RING       buzzer enable (registered)
//   SNOOZING   high while waiting out a snooze (registered)
//   SNOOZE_CNT snoozes used in the current alarm event (registered)
//   TIMEOUT    one-cycle pulse when a ring ends unattended (registered)
module alarm_controller #(
  parameter int unsigned RING_SECS   = 60,
  parameter int unsigned SNOOZE_SECS = 300,
  parameter int unsigned MAX_SNOOZE  = 3,
  parameter int unsigned TW          = 9
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       TICK_1HZ,
  input  logic       SAME,
  input  logic       ALARM_EN,
  input  logic       SNOOZE,
  input  logic       STOP,
  output logic       RING,
  output logic       SNOOZING,
  output logic [1:0] SNOOZE_CNT,
  output logic       TIMEOUT
);

  localparam int unsigned CW = 2;
  localparam logic [TW-1:0] RING_LAST   = TW'(RING_SECS - 1);
  localparam logic [TW-1:0] SNOOZE_LAST = TW'(SNOOZE_SECS - 1);
  localparam logic [CW-1:0] SNOOZE_MAX  = CW'(MAX_SNOOZE);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    RINGING     = 2'd1,
    SNOOZE_WAIT = 2'd2
  } state_t;

  state_t         state, state_nx;
  logic [TW-1:0]  timer, timer_nx;
  logic [CW-1:0]  cnt_nx;
  logic           timeout_nx;
  logic           same_d;
  logic           trigger;

  // Only a fresh rising edge of SAME while armed starts an alarm event.
  assign trigger = SAME & ~same_d & ALARM_EN;

  // State, timer and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      timer      <= '0;
      same_d     <= 1'b1;  // a match already in progress at reset never fires
      RING       <= 1'b0;
      SNOOZING   <= 1'b0;
      SNOOZE_CNT <= '0;
      TIMEOUT    <= 1'b0;
    end else begin
      state      <= state_nx;
      timer      <= timer_nx;
      same_d     <= SAME;
      RING       <= (state_nx == RINGING);
      SNOOZING   <= (state_nx == SNOOZE_WAIT);
      SNOOZE_CNT <= cnt_nx;
      TIMEOUT    <= timeout_nx;
    end
  end

  // Next-state logic: disable > stop > snooze > timer expiry.
  always_comb begin
    state_nx   = state;
    timer_nx   = timer;
    cnt_nx     = SNOOZE_CNT;
    timeout_nx = 1'b0;

    if (!ALARM_EN) begin
      state_nx = IDLE;
      timer_nx = '0;
      cnt_nx   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (trigger) begin
            state_nx = RINGING;
            timer_nx = '0;
            cnt_nx   = '0;
          end
        end
        RINGING: begin
          if (STOP) begin
            state_nx = IDLE;
            timer_nx = '0;
            cnt_nx   = '0;
          end else if (SNOOZE && (SNOOZE_CNT < SNOOZE_MAX)) begin
            state_nx = SNOOZE_WAIT;
            timer_nx = '0;
            cnt_nx   = SNOOZE_CNT + CW'(1);
          end else if (TICK_1HZ) begin
            if (timer >= RING_LAST) begin
              state_nx   = IDLE;
              timer_nx   = '0;
              cnt_nx     = '0;
              timeout_nx = 1'b1;
            end else begin
              timer_nx = timer + TW'(1);
            end
          end
        end
        SNOOZE_WAIT: begin
          if (STOP) begin
            state_nx = IDLE;
            timer_nx = '0;
            cnt_nx   = '0;
          end else if (TICK_1HZ) begin
            if (timer >= SNOOZE_LAST) begin
              state_nx = RINGING;
              timer_nx = '0;
            end else begin
              timer_nx = timer + TW'(1);
            end
          end
        end
        default: begin
          state_nx = IDLE;
          timer_nx = '0;
          cnt_nx   = '0;
        end
      endcase
    end
  end

endmodule
